rdma_traffic_gen: RTL and testbench
===================================

Name: rdma_traffic_gen

Overview:
Parametrised RDMA request generator, successor to the single-mode READ role kernel. Issues a configured number of RDMA READ or WRITE work requests round-robin across NUM_QP queue pairs. Streams the WRITE payload and bounds in-flight requests using tx_status completions. Sits between the host control interface and the RoCE stack tx_meta/tx_data/tx_status streams.

Parameters:
META_W, 256, tx_meta tdata width (>=155)
DATA_W, 512, tx_data tdata width (multiple of 32)
STATUS_W, 512, tx_status tdata width (payload ignored)
NUM_QP, 4, number of QPs rotated through (1..256)
MAX_OUTSTANDING, 8, max issued-but-uncompleted requests (1..255)

Ports:
ap_clk  in  1  clock
areset  in  1  synchronous active-high reset
ap_start  in  1  rising edge starts a run
ap_idle  out  1  high when no run active
ap_done  out  1  one-cycle pulse at run end
cfg_opcode  in  3  0=RDMA READ, 1=RDMA WRITE; others treated as READ
cfg_qpn_base  in  24  first local QPN
cfg_len_log2  in  5  request length = 2^cfg_len_log2 bytes
cfg_num_reqs  in  32  total requests to issue
m_axis_tx_meta_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/META_W/META_W/8/1  work-request stream
m_axis_tx_data_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  WRITE payload stream
s_axis_tx_status_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/STATUS_W/STATUS_W/8/1  completion stream
stat_issued  out  32  requests accepted on tx_meta this run
stat_completed  out  32  status beats counted this run
err_underflow  out  1  sticky: status received with zero outstanding

Behaviour:
- Reset: all tvalid 0, ap_idle 1, ap_done 0, stats 0, err_underflow 0, state IDLE. Reset mid-run aborts immediately; tvalid outputs drop the next cycle.
- Start: ap_start & ~ap_start_r in IDLE latches all cfg_* inputs, clears stats, offset, qp_idx, outstanding and err_underflow, drops ap_idle, and moves to ISSUE. ap_start is ignored outside IDLE.
- Length: eff_log2 = max(cfg_len_log2, log2(DATA_W/8)). len = 1 << eff_log2 (32-bit).
- Meta fields: [2:0] opcode; [26:3] cfg_qpn_base+qp_idx (24-bit wrap); [74:27] lAddr=offset; [122:75] rAddr=offset; [154:123] len. All other bits are 0. tkeep is all-ones and tlast is 1.
- States:
  - IDLE.
  - ISSUE: meta_tvalid=1 when issued<num_reqs and outstanding<MAX_OUTSTANDING. On handshake: issued++, outstanding++, offset+=len (48-bit wrap), qp_idx wraps from NUM_QP-1 to 0. Next state: DATA if WRITE; otherwise stay in ISSUE so meta stays valid back-to-back, one request per cycle.
  - DATA: beats = len/(DATA_W/8). tdata = replicated 32-bit beat index (0..beats-1). tkeep is all-ones; tlast on the final beat. Final-beat handshake returns to ISSUE. The next meta is never presented before the final beat is accepted.
  - DRAIN: entered when issued==num_reqs; waits until outstanding==0.
  - DONE: one cycle; ap_done=1, ap_idle=1 next cycle, return to IDLE.
- num_reqs==0: ISSUE goes straight to DRAIN, and ap_done pulses 2 cycles after the start pulse.
- AXIS: tvalid, once high, holds with stable tdata until tready. s_axis_tx_status_tready is always 1.
- Outstanding counter: +1 on meta handshake, -1 on status beat. Both in the same cycle leaves it unchanged. A status beat at outstanding 0 (and no simultaneous meta handshake) sets err_underflow and is not counted.

Test Plan:
- READ, num_reqs=4, len_log2=12, NUM_QP=4, qpn_base=0x10, tready=1, status returned 3 cycles after each meta -> QPNs 0x10..0x13; lAddr 0,0x1000,0x2000,0x3000; len 0x1000; ap_done once; stat_issued=stat_completed=4.
- WRITE, num_reqs=2, len_log2=8, DATA_W=512 -> per request: 1 meta, then 4 data beats with tdata words 0,1,2,3 and tlast on beat 3; the second meta appears only after that tlast handshake.
- MAX_OUTSTANDING=2, READ num_reqs=5, status withheld -> meta_tvalid low after 2 issues; each status releases exactly one more request; done after the 5th status.
- tready toggled randomly -> meta/data tdata stable while valid & !tready; no beat lost or duplicated.
- Status beat with outstanding 0 -> err_underflow=1, stat_completed unchanged. Simultaneous meta handshake and status -> outstanding unchanged.
- num_reqs=0 -> ap_done 2 cycles after start. Reset asserted mid-WRITE -> all tvalid 0 next cycle and ap_idle=1; a fresh start then runs cleanly.

Source files
------------

// File: rtl/rdma_traffic_gen.sv
// rdma_traffic_gen: issues a configured number of RDMA READ/WRITE work requests
// round-robin across NUM_QP queue pairs. It streams WRITE payload beats and caps
// in-flight requests using tx_status completions.
// Ports:
//   ap_clk / areset          clock, synchronous active-high reset
//   ap_start/ap_idle/ap_done host run control (rising edge of ap_start starts a run)
//   cfg_*                    run configuration, latched at start
//   m_axis_tx_meta_*         work-request stream to the RoCE stack
//   m_axis_tx_data_*         WRITE payload stream
//   s_axis_tx_status_*       completion stream (payload ignored, always ready)
//   stat_issued/completed    per-run counters; err_underflow is sticky
module rdma_traffic_gen #(
  parameter int unsigned META_W          = 256,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned STATUS_W        = 512,
  parameter int unsigned NUM_QP          = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [2:0]            cfg_opcode,
  input  logic [23:0]           cfg_qpn_base,
  input  logic [4:0]            cfg_len_log2,
  input  logic [31:0]           cfg_num_reqs,
  output logic                  m_axis_tx_meta_tvalid,
  input  logic                  m_axis_tx_meta_tready,
  output logic [META_W-1:0]     m_axis_tx_meta_tdata,
  output logic [META_W/8-1:0]   m_axis_tx_meta_tkeep,
  output logic                  m_axis_tx_meta_tlast,
  output logic                  m_axis_tx_data_tvalid,
  input  logic                  m_axis_tx_data_tready,
  output logic [DATA_W-1:0]     m_axis_tx_data_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tx_data_tkeep,
  output logic                  m_axis_tx_data_tlast,
  input  logic                  s_axis_tx_status_tvalid,
  output logic                  s_axis_tx_status_tready,
  input  logic [STATUS_W-1:0]   s_axis_tx_status_tdata,
  input  logic [STATUS_W/8-1:0] s_axis_tx_status_tkeep,
  input  logic                  s_axis_tx_status_tlast,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_completed,
  output logic                  err_underflow
);

  localparam int unsigned BYTES_LOG2 = $clog2(DATA_W / 8);
  localparam int unsigned OUT_W      = 8;
  localparam int unsigned QP_W       = 8;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned ADDR_W     = 48;
  localparam int unsigned REP        = DATA_W / 32;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DATA, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                start_r_q, start_r_d;
  logic                write_q, write_d;
  logic [23:0]         qpn_base_q, qpn_base_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    last_beat_q, last_beat_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    completed_q, completed_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [QP_W-1:0]     qp_idx_q, qp_idx_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic                err_q, err_d;
  logic                ap_idle_q, ap_idle_d;
  logic                ap_done_q, ap_done_d;
  logic                meta_valid_q, meta_valid_d;
  logic [META_W-1:0]   meta_data_q, meta_data_d;
  logic                data_valid_q, data_valid_d;
  logic                data_last_q, data_last_d;
  logic [DATA_W-1:0]   data_data_q, data_data_d;

  logic                meta_hs, data_hs, status_ok;
  logic [4:0]          eff_log2;
  logic                status_unused;

  assign status_unused = ^{s_axis_tx_status_tdata, s_axis_tx_status_tkeep, s_axis_tx_status_tlast};

  // Next-state, counters and registered output values.
  always_comb begin
    state_d       = state_q;
    start_r_d     = ap_start;
    write_d       = write_q;
    qpn_base_d    = qpn_base_q;
    len_d         = len_q;
    last_beat_d   = last_beat_q;
    num_d         = num_q;
    issued_d      = issued_q;
    completed_d   = completed_q;
    outstanding_d = outstanding_q;
    offset_d      = offset_q;
    qp_idx_d      = qp_idx_q;
    beat_d        = beat_q;
    err_d         = err_q;

    meta_hs   = meta_valid_q & m_axis_tx_meta_tready;
    data_hs   = data_valid_q & m_axis_tx_data_tready;
    // A completion at zero outstanding is only legal if a request is issued in the same cycle.
    status_ok = s_axis_tx_status_tvalid & ((outstanding_q != '0) | meta_hs);
    eff_log2  = (cfg_len_log2 < 5'(BYTES_LOG2)) ? 5'(BYTES_LOG2) : cfg_len_log2;

    if (status_ok) begin
      completed_d = completed_q + CNT_W'(1);
    end else if (s_axis_tx_status_tvalid) begin
      err_d = 1'b1;
    end

    if (meta_hs && !status_ok) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!meta_hs && status_ok) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (ap_start && !start_r_q) begin
          write_d       = (cfg_opcode == 3'd1);
          qpn_base_d    = cfg_qpn_base;
          len_d         = CNT_W'(1) << eff_log2;
          last_beat_d   = (CNT_W'(1) << (eff_log2 - 5'(BYTES_LOG2))) - CNT_W'(1);
          num_d         = cfg_num_reqs;
          issued_d      = '0;
          completed_d   = '0;
          outstanding_d = '0;
          offset_d      = '0;
          qp_idx_d      = '0;
          err_d         = 1'b0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (meta_hs) begin
          issued_d = issued_q + CNT_W'(1);
          offset_d = offset_q + ADDR_W'(len_q);
          qp_idx_d = (qp_idx_q == QP_W'(NUM_QP - 1)) ? '0 : qp_idx_q + QP_W'(1);
          if (write_q) begin
            beat_d  = '0;
            state_d = S_DATA;
          end
        end else if (issued_q == num_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DATA: begin
        if (data_hs) begin
          if (beat_q == last_beat_q) begin
            state_d = S_ISSUE;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (outstanding_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Valid can only rise while stalled, never fall, since outstanding only drops without a handshake.
    meta_valid_d = (state_d == S_ISSUE) && (issued_d < num_d) &&
                   (outstanding_d < OUT_W'(MAX_OUTSTANDING));
    data_valid_d = (state_d == S_DATA);
    data_last_d  = (beat_d == last_beat_d);
    data_data_d  = {REP{beat_d}};
    ap_idle_d    = (state_d == S_IDLE);
    ap_done_d    = (state_d == S_DONE);

    meta_data_d            = '0;
    meta_data_d[2:0]       = write_d ? 3'd1 : 3'd0;
    meta_data_d[26:3]      = qpn_base_d + 24'(qp_idx_d);
    meta_data_d[74:27]     = offset_d;
    meta_data_d[122:75]    = offset_d;
    meta_data_d[154:123]   = len_d;
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q       <= S_IDLE;
      start_r_q     <= 1'b0;
      write_q       <= 1'b0;
      qpn_base_q    <= '0;
      len_q         <= '0;
      last_beat_q   <= '0;
      num_q         <= '0;
      issued_q      <= '0;
      completed_q   <= '0;
      outstanding_q <= '0;
      offset_q      <= '0;
      qp_idx_q      <= '0;
      beat_q        <= '0;
      err_q         <= 1'b0;
      ap_idle_q     <= 1'b1;
      ap_done_q     <= 1'b0;
      meta_valid_q  <= 1'b0;
      meta_data_q   <= '0;
      data_valid_q  <= 1'b0;
      data_last_q   <= 1'b0;
      data_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      start_r_q     <= start_r_d;
      write_q       <= write_d;
      qpn_base_q    <= qpn_base_d;
      len_q         <= len_d;
      last_beat_q   <= last_beat_d;
      num_q         <= num_d;
      issued_q      <= issued_d;
      completed_q   <= completed_d;
      outstanding_q <= outstanding_d;
      offset_q      <= offset_d;
      qp_idx_q      <= qp_idx_d;
      beat_q        <= beat_d;
      err_q         <= err_d;
      ap_idle_q     <= ap_idle_d;
      ap_done_q     <= ap_done_d;
      meta_valid_q  <= meta_valid_d;
      meta_data_q   <= meta_data_d;
      data_valid_q  <= data_valid_d;
      data_last_q   <= data_last_d;
      data_data_q   <= data_data_d;
    end
  end

  assign ap_idle                 = ap_idle_q;
  assign ap_done                 = ap_done_q;
  assign m_axis_tx_meta_tvalid   = meta_valid_q;
  assign m_axis_tx_meta_tdata    = meta_data_q;
  assign m_axis_tx_meta_tkeep    = '1;
  assign m_axis_tx_meta_tlast    = 1'b1;
  assign m_axis_tx_data_tvalid   = data_valid_q;
  assign m_axis_tx_data_tdata    = data_data_q;
  assign m_axis_tx_data_tkeep    = '1;
  assign m_axis_tx_data_tlast    = data_last_q;
  assign s_axis_tx_status_tready = 1'b1;
  assign stat_issued             = issued_q;
  assign stat_completed          = completed_q;
  assign err_underflow           = err_q;

endmodule

// File: tb/tb_rdma_traffic_gen.sv
// Directed bench for rdma_traffic_gen: READ/WRITE runs, back-pressure,
// outstanding limit, underflow, zero-request run and mid-run reset.
module tb_rdma_traffic_gen;
  localparam int unsigned META_W   = 256;
  localparam int unsigned DATA_W   = 512;
  localparam int unsigned STATUS_W = 64;
  localparam int unsigned NUM_QP   = 4;
  localparam int unsigned MAX_OUT  = 2;

  logic                  ap_clk = 1'b0;
  logic                  areset, ap_start, ap_idle, ap_done;
  logic [2:0]            cfg_opcode;
  logic [23:0]           cfg_qpn_base;
  logic [4:0]            cfg_len_log2;
  logic [31:0]           cfg_num_reqs;
  logic                  m_tvalid, m_tready, m_tlast;
  logic [META_W-1:0]     m_tdata;
  logic [META_W/8-1:0]   m_tkeep;
  logic                  d_tvalid, d_tready, d_tlast;
  logic [DATA_W-1:0]     d_tdata;
  logic [DATA_W/8-1:0]   d_tkeep;
  logic                  s_tvalid, s_tready;
  logic [STATUS_W-1:0]   s_tdata;
  logic [STATUS_W/8-1:0] s_tkeep;
  logic                  s_tlast;
  logic [31:0]           stat_issued, stat_completed;
  logic                  err_underflow;

  always #5 ap_clk = ~ap_clk;

  rdma_traffic_gen #(
    .META_W(META_W), .DATA_W(DATA_W), .STATUS_W(STATUS_W),
    .NUM_QP(NUM_QP), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
    .cfg_opcode(cfg_opcode), .cfg_qpn_base(cfg_qpn_base), .cfg_len_log2(cfg_len_log2),
    .cfg_num_reqs(cfg_num_reqs),
    .m_axis_tx_meta_tvalid(m_tvalid), .m_axis_tx_meta_tready(m_tready),
    .m_axis_tx_meta_tdata(m_tdata), .m_axis_tx_meta_tkeep(m_tkeep), .m_axis_tx_meta_tlast(m_tlast),
    .m_axis_tx_data_tvalid(d_tvalid), .m_axis_tx_data_tready(d_tready),
    .m_axis_tx_data_tdata(d_tdata), .m_axis_tx_data_tkeep(d_tkeep), .m_axis_tx_data_tlast(d_tlast),
    .s_axis_tx_status_tvalid(s_tvalid), .s_axis_tx_status_tready(s_tready),
    .s_axis_tx_status_tdata(s_tdata), .s_axis_tx_status_tkeep(s_tkeep), .s_axis_tx_status_tlast(s_tlast),
    .stat_issued(stat_issued), .stat_completed(stat_completed), .err_underflow(err_underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Control written by the main sequence only; the *_ack side by the monitor only.
  int ready_mode  = 1;  // 0 hold low, 1 always high, 2 random
  int auto_status = 1;  // return one status 3 cycles after each meta handshake
  int man_req = 0, man_ack = 0;
  int both_req = 0, both_ack = 0;
  int flush_req = 0, flush_ack = 0;

  // Observations written by the monitor only.
  int            cyc = 0;
  int            pend[$];
  int            ev[$];          // 100 = meta handshake, otherwise data beat word 0
  logic [154:0]  mq[$];
  logic          mfmt[$];
  logic          lastq[$];
  logic          repq[$];
  int            done_cnt = 0;
  int            hold_checks = 0, hold_err = 0;
  logic          meta_stall = 1'b0, data_stall = 1'b0;
  logic [META_W-1:0] meta_prev;
  logic [DATA_W-1:0] data_prev;
  logic          last_prev;

  // Drives ready/status for the coming posedge, then records what that edge will accept.
  always @(negedge ap_clk) begin
    cyc++;
    if (flush_req != flush_ack) begin
      pend.delete();
      flush_ack = flush_req;
    end
    m_tready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    d_tready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    s_tvalid = 1'b0;
    if (both_req != both_ack) begin
      m_tready = 1'b1;
      s_tvalid = 1'b1;
      both_ack = both_req;
    end else if (man_req != man_ack) begin
      s_tvalid = 1'b1;
      man_ack++;
    end else if (pend.size() > 0 && pend[0] <= cyc) begin
      s_tvalid = 1'b1;
      void'(pend.pop_front());
    end

    if (!areset && meta_stall) begin
      hold_checks++;
      if (!(m_tvalid && m_tdata == meta_prev)) hold_err++;
    end
    if (!areset && data_stall) begin
      hold_checks++;
      if (!(d_tvalid && d_tdata == data_prev && d_tlast == last_prev)) hold_err++;
    end
    meta_stall = m_tvalid && !m_tready;
    meta_prev  = m_tdata;
    data_stall = d_tvalid && !d_tready;
    data_prev  = d_tdata;
    last_prev  = d_tlast;

    if (!areset) begin
      if (m_tvalid && m_tready) begin
        ev.push_back(100);
        mq.push_back(m_tdata[154:0]);
        mfmt.push_back((m_tdata[META_W-1:155] == '0) && (&m_tkeep) && m_tlast);
        if (auto_status != 0) pend.push_back(cyc + 3);
      end
      if (d_tvalid && d_tready) begin
        ev.push_back(int'(d_tdata[31:0]));
        lastq.push_back(d_tlast);
        repq.push_back((d_tdata == {(DATA_W/32){d_tdata[31:0]}}) && (&d_tkeep));
      end
      if (ap_done) done_cnt++;
    end
  end

  int ev_base, mq_base, dq_base, done_base;
  int exp_ev[$];

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic run_start(input logic [2:0] op, input logic [23:0] base,
                           input logic [4:0] l2, input logic [31:0] n);
    ev_base   = ev.size();
    mq_base   = mq.size();
    dq_base   = lastq.size();
    done_base = done_cnt;
    cfg_opcode   = op;
    cfg_qpn_base = base;
    cfg_len_log2 = l2;
    cfg_num_reqs = n;
    ap_start = 1'b1;
    wait_cycles(1);
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == done_base && k < budget) begin
      wait_cycles(1);
      k++;
    end
    wait_cycles(1);
    check("done_pulses", 64'(done_cnt - done_base), 1);
  endtask

  task automatic check_meta(input int i, input logic [2:0] op, input logic [23:0] qpn,
                            input logic [47:0] addr, input logic [31:0] len);
    logic [154:0] m;
    if (mq.size() > mq_base + i) begin
      m = mq[mq_base + i];
      check($sformatf("meta%0d_op", i), 64'(m[2:0]), 64'(op));
      check($sformatf("meta%0d_qpn", i), 64'(m[26:3]), 64'(qpn));
      check($sformatf("meta%0d_laddr", i), 64'(m[74:27]), 64'(addr));
      check($sformatf("meta%0d_raddr", i), 64'(m[122:75]), 64'(addr));
      check($sformatf("meta%0d_len", i), 64'(m[154:123]), 64'(len));
    end else begin
      check($sformatf("meta%0d_present", i), 0, 1);
    end
  endtask

  task automatic build_write_ev(input int nreq, input int beats);
    exp_ev.delete();
    for (int r = 0; r < nreq; r++) begin
      exp_ev.push_back(100);
      for (int b = 0; b < beats; b++) exp_ev.push_back(b);
    end
  endtask

  task automatic check_write_stream(input string tag, input int beats);
    int bad = 0;
    check({tag, "_events"}, 64'(ev.size() - ev_base), 64'(exp_ev.size()));
    for (int i = 0; i < exp_ev.size() && ev_base + i < ev.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), 64'(ev[ev_base + i]), 64'(exp_ev[i]));
    for (int i = dq_base; i < lastq.size(); i++) begin
      check($sformatf("%s_tlast%0d", tag, i - dq_base), 64'(lastq[i]),
            64'(((i - dq_base) % beats) == beats - 1));
      if (!repq[i]) bad++;
    end
    check({tag, "_replicated"}, 64'(bad), 0);
  endtask

  initial begin
    areset = 1'b1; ap_start = 1'b0;
    cfg_opcode = '0; cfg_qpn_base = '0; cfg_len_log2 = '0; cfg_num_reqs = '0;
    m_tready = 1'b0; d_tready = 1'b0; s_tvalid = 1'b0;
    s_tdata = '0; s_tkeep = '1; s_tlast = 1'b1;
    wait_cycles(3);
    check("rst_meta_valid", 64'(m_tvalid), 0);
    check("rst_data_valid", 64'(d_tvalid), 0);
    check("rst_idle", 64'(ap_idle), 1);
    check("rst_done", 64'(ap_done), 0);
    check("rst_issued", 64'(stat_issued), 0);
    check("rst_completed", 64'(stat_completed), 0);
    check("rst_err", 64'(err_underflow), 0);
    check("status_ready", 64'(s_tready), 1);
    areset = 1'b0;
    wait_cycles(2);

    // READ, 4 requests of 4 KiB over 4 QPs.
    run_start(3'd0, 24'h10, 5'd12, 32'd4);
    check("t1_idle_low", 64'(ap_idle), 0);
    wait_done(300);
    check("t1_meta_count", 64'(mq.size() - mq_base), 4);
    for (int i = 0; i < 4; i++) check_meta(i, 3'd0, 24'h10 + 24'(i), 48'(i) * 48'h1000, 32'h1000);
    check("t1_meta_fmt", 64'(mfmt[mq_base]), 1);
    check("t1_issued", 64'(stat_issued), 4);
    check("t1_completed", 64'(stat_completed), 4);
    check("t1_idle", 64'(ap_idle), 1);
    check("t1_err", 64'(err_underflow), 0);

    // WRITE, 2 x 256 B = 4 beats each; meta never overtakes the payload.
    run_start(3'd1, 24'h100, 5'd8, 32'd2);
    wait_done(300);
    build_write_ev(2, 4);
    check_write_stream("t2", 4);
    check_meta(0, 3'd1, 24'h100, 48'h0, 32'h100);
    check_meta(1, 3'd1, 24'h101, 48'h100, 32'h100);

    // WRITE under random back-pressure, QPN wraps at 24 bits.
    ready_mode = 2;
    run_start(3'd1, 24'hFFFFFE, 5'd7, 32'd3);
    wait_done(600);
    build_write_ev(3, 2);
    check_write_stream("t4w", 2);
    check_meta(2, 3'd1, 24'h000000, 48'h100, 32'h80);

    // READ with short length clamps to one bus word, random back-pressure.
    run_start(3'd0, 24'h50, 5'd2, 32'd3);
    wait_done(600);
    check("t4r_meta_count", 64'(mq.size() - mq_base), 3);
    check_meta(2, 3'd0, 24'h52, 48'h80, 32'h40);
    check("t4_hold_violations", 64'(hold_err), 0);
    check("t4_hold_exercised", 64'(hold_checks > 0), 1);

    // Outstanding limit of 2 with completions withheld.
    ready_mode = 1;
    auto_status = 0;
    run_start(3'd0, 24'h0, 5'd12, 32'd5);
    wait_cycles(10);
    check("t3_stalled_count", 64'(mq.size() - mq_base), 2);
    check("t3_stalled_valid", 64'(m_tvalid), 0);
    for (int k = 0; k < 3; k++) begin
      man_req++;
      wait_cycles(6);
      check($sformatf("t3_release%0d", k), 64'(mq.size() - mq_base), 64'(3 + k));
    end
    check("t3_issued", 64'(stat_issued), 5);
    man_req++;
    wait_cycles(6);
    check("t3_no_early_done", 64'(done_cnt - done_base), 0);
    man_req++;
    wait_done(20);
    check("t3_completed", 64'(stat_completed), 5);

    // Completion with nothing outstanding.
    man_req++;
    wait_cycles(4);
    check("t5_underflow", 64'(err_underflow), 1);
    check("t5_completed_kept", 64'(stat_completed), 5);

    // Meta handshake and completion in the same cycle at zero outstanding.
    ready_mode = 0;
    run_start(3'd0, 24'h30, 5'd12, 32'd1);
    check("t5_err_cleared", 64'(err_underflow), 0);
    wait_cycles(3);
    check("t5_meta_waiting", 64'(m_tvalid), 1);
    both_req++;
    wait_done(20);
    check("t5_both_err", 64'(err_underflow), 0);
    check("t5_both_issued", 64'(stat_issued), 1);
    check("t5_both_completed", 64'(stat_completed), 1);
    check_meta(0, 3'd0, 24'h30, 48'h0, 32'h1000);

    // Zero requests: ap_done two edges after the start edge.
    ready_mode = 1;
    run_start(3'd0, 24'h0, 5'd12, 32'd0);
    check("t6_done_e0", 64'(ap_done), 0);
    check("t6_idle_e0", 64'(ap_idle), 0);
    wait_cycles(1);
    check("t6_done_e1", 64'(ap_done), 0);
    wait_cycles(1);
    check("t6_done_e2", 64'(ap_done), 1);
    wait_cycles(1);
    check("t6_done_e3", 64'(ap_done), 0);
    check("t6_idle_e3", 64'(ap_idle), 1);
    check("t6_issued", 64'(stat_issued), 0);

    // Reset in the middle of a WRITE payload, then a clean READ run.
    auto_status = 1;
    run_start(3'd1, 24'h40, 5'd10, 32'd4);
    wait_cycles(3);
    check("t7_mid_write", 64'(d_tvalid), 1);
    areset = 1'b1;
    flush_req++;
    wait_cycles(1);
    check("t7_rst_meta_valid", 64'(m_tvalid), 0);
    check("t7_rst_data_valid", 64'(d_tvalid), 0);
    check("t7_rst_idle", 64'(ap_idle), 1);
    check("t7_rst_issued", 64'(stat_issued), 0);
    areset = 1'b0;
    wait_cycles(2);
    run_start(3'd0, 24'h20, 5'd12, 32'd6);
    wait_done(400);
    check("t7_meta_count", 64'(mq.size() - mq_base), 6);
    check_meta(4, 3'd0, 24'h20, 48'h4000, 32'h1000);
    check_meta(5, 3'd0, 24'h21, 48'h5000, 32'h1000);
    check("t7_completed", 64'(stat_completed), 6);
    check("t7_err", 64'(err_underflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
